// File: rtl/serial_subtractor_8bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit
//   Bit-serial 8-bit subtractor computing X - Y - Bin (mod 256), LSB first,
//   one bit per clock through a single full-subtractor cell.
//
//   Optional feature: define OVERFLOW_FLAG_EN to add the signed-overflow
//   output V and its logic.
//
// Ports
//   clk    in   1  clock, rising edge
//   rst_n  in   1  synchronous active-low reset
//   X      in   8  minuend     (captured only when a start is accepted)
//   Y      in   8  subtrahend  (captured only when a start is accepted)
//   Bin    in   1  borrow-in   (captured only when a start is accepted)
//   start  in   1  operation request, level-sampled on every edge
//   D      out  8  registered difference
//   Bout   out  1  registered borrow-out (X < Y + Bin, unsigned)
//   busy   out  1  operation in progress (state RUN)
//   done   out  1  one-cycle pulse: D/Bout (and V) just updated
//   V      out  1  signed overflow, only with OVERFLOW_FLAG_EN
//
// Handshake: start is accepted only on an edge where the block is IDLE
// (busy=0 and done=0); a start seen in RUN or DONE is dropped, not queued.
// Once accepted, busy is high for exactly 8 cycles, then done pulses for one
// cycle with the new result. Holding start high re-launches on each IDLE
// cycle, giving one result every 10 cycles.
// ---------------------------------------------------------------------------
module serial_subtractor_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  input  logic       Bin,
  input  logic       start,
  output logic [7:0] D,
  output logic       Bout,
  output logic       busy,
  output logic       done
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic       V
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] x_sh_q, x_sh_d;
  logic [7:0] y_sh_q, y_sh_d;
  // Holds the difference bits already produced; bit 7 comes straight from
  // the cell on the final edge, so only 7 bits need storing.
  logic [6:0] d_sh_q, d_sh_d;
  logic       b_q, b_d;
  logic [7:0] d_q, d_d;
  logic       bout_q, bout_d;
`ifdef OVERFLOW_FLAG_EN
  logic       v_q, v_d;
`endif

  // Full-subtractor cell on the current LSBs of the shift registers.
  logic x_i, y_i, diff_i, b_next;
  assign x_i    = x_sh_q[0];
  assign y_i    = y_sh_q[0];
  assign diff_i = x_i ^ y_i ^ b_q;
  assign b_next = (~x_i & y_i) | (~(x_i ^ y_i) & b_q);

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      x_sh_q  <= 8'd0;
      y_sh_q  <= 8'd0;
      d_sh_q  <= 7'd0;
      b_q     <= 1'b0;
      d_q     <= 8'd0;
      bout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_sh_q  <= x_sh_d;
      y_sh_q  <= y_sh_d;
      d_sh_q  <= d_sh_d;
      b_q     <= b_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef OVERFLOW_FLAG_EN
      v_q     <= v_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == 3'd7) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    cnt_d  = cnt_q;
    x_sh_d = x_sh_q;
    y_sh_d = y_sh_q;
    d_sh_d = d_sh_q;
    b_d    = b_q;
    d_d    = d_q;
    bout_d = bout_q;
`ifdef OVERFLOW_FLAG_EN
    v_d    = v_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_sh_d = X;
          y_sh_d = Y;
          b_d    = Bin;
          cnt_d  = 3'd0;
          d_sh_d = 7'd0;
        end
      end
      S_RUN: begin
        x_sh_d = {1'b0, x_sh_q[7:1]};
        y_sh_d = {1'b0, y_sh_q[7:1]};
        d_sh_d = {diff_i, d_sh_q[6:1]};
        b_d    = b_next;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Bit 7 is in the cell now: x_i/y_i are the sign bits and diff_i
          // is the sign of the final difference.
          d_d    = {diff_i, d_sh_q};
          bout_d = b_next;
`ifdef OVERFLOW_FLAG_EN
          v_d    = (x_i ^ y_i) & (x_i ^ diff_i);
`endif
        end
      end
      default: ;
    endcase
  end

  // Outputs: registered-state decodes and result registers.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    D    = d_q;
    Bout = bout_q;
`ifdef OVERFLOW_FLAG_EN
    V    = v_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_8bit
//   Directed self-checking bench for serial_subtractor_8bit. Inputs are
//   driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] X, Y;
  logic       Bin;
  logic       start;
  logic [7:0] D;
  logic       Bout;
  logic       busy;
  logic       done;
`ifdef OVERFLOW_FLAG_EN
  logic       V;
`endif

  int checks   = 0;
  int failures = 0;

  // Scoreboard for the back-to-back section: {V, Bout, D}.
  logic [9:0] exp_q[$];

  serial_subtractor_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X     (X),
    .Y     (Y),
    .Bin   (Bin),
    .start (start),
    .D     (D),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef OVERFLOW_FLAG_EN
    ,
    .V     (V)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic b);
    X = x; Y = y; Bin = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Call right after the accepting edge: 8 busy cycles, then one done cycle.
  task automatic expect_result(input string tag, input logic [7:0] exp_d,
                               input logic exp_b, input logic exp_v);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      step();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_D"}, {24'd0, D}, {24'd0, exp_d});
    check({tag, "_Bout"}, {31'd0, Bout}, {31'd0, exp_b});
`ifdef OVERFLOW_FLAG_EN
    check({tag, "_V"}, {31'd0, V}, {31'd0, exp_v});
`else
    if (exp_v !== exp_v) $display("unreachable");
`endif
    step();
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_D_hold"}, {24'd0, D}, {24'd0, exp_d});
  endtask

  // Stimulus
  initial begin
    logic [7:0] rx, ry;
    logic       rb;
    logic [8:0] full;
    logic [9:0] exp_e;

    rst_n = 1'b0; start = 1'b0; X = 8'h00; Y = 8'h00; Bin = 1'b0;
    step();
    step();
    check("rst_D", {24'd0, D}, 32'h0);
    check("rst_Bout", {31'd0, Bout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef OVERFLOW_FLAG_EN
    check("rst_V", {31'd0, V}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Basic operation and boundary vectors
    start_op(8'h50, 8'h30, 1'b0);
    expect_result("v50_30", 8'h20, 1'b0, 1'b0);
    start_op(8'h00, 8'h01, 1'b0);
    expect_result("v00_01", 8'hFF, 1'b1, 1'b0);
    start_op(8'hFF, 8'hFF, 1'b1);
    expect_result("vFF_FF_b", 8'hFF, 1'b1, 1'b0);
    start_op(8'h80, 8'h01, 1'b0);
    expect_result("v80_01", 8'h7F, 1'b0, 1'b1);
    start_op(8'h10, 8'h01, 1'b0);
    expect_result("v10_01", 8'h0F, 1'b0, 1'b0);

    // Second start during RUN is ignored; operand changes do not leak in.
    start_op(8'h0A, 8'h03, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("ign_busy", {31'd0, busy}, 32'd1);
      if (i == 3) begin
        start = 1'b1; X = 8'h77; Y = 8'h11;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_D", {24'd0, D}, 32'h07);
    step();
    check("ign_idle_done", {31'd0, done}, 32'd0);
    step();
    check("ign_no_queue", {31'd0, busy}, 32'd0);

    // Reset mid-operation
    start_op(8'h40, 8'h11, 1'b0);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_D", {24'd0, D}, 32'h0);
    check("abort_Bout", {31'd0, Bout}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    start_op(8'h05, 8'h02, 1'b0);
    expect_result("v05_02", 8'h03, 1'b0, 1'b0);

    // Reset dominates start
    rst_n = 1'b0; start = 1'b1; X = 8'h12; Y = 8'h34;
    step();
    check("rst_dom_busy", {31'd0, busy}, 32'd0);
    check("rst_dom_D", {24'd0, D}, 32'h0);
    rst_n = 1'b1; start = 1'b0;
    step();

    // Back-to-back with start held for 25 cycles: accepts at cycles 0,10,20.
    for (int c = 0; c < 30; c++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rb = 1'($urandom_range(0, 1));
      X = rx; Y = ry; Bin = rb;
      start = (c < 25);
      if (c % 10 == 0) begin
        full  = {1'b0, rx} - {1'b0, ry} - {8'd0, rb};
        exp_e = {(rx[7] ^ ry[7]) & (rx[7] ^ full[7]), full[8], full[7:0]};
        exp_q.push_back(exp_e);
      end
      step();
      check("b2b_busy", {31'd0, busy}, {31'd0, (c % 10) < 8});
      check("b2b_done", {31'd0, done}, {31'd0, (c % 10) == 8});
      if ((c % 10) == 8 && exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check("b2b_D", {24'd0, D}, {24'd0, exp_e[7:0]});
        check("b2b_Bout", {31'd0, Bout}, {31'd0, exp_e[8]});
`ifdef OVERFLOW_FLAG_EN
        check("b2b_V", {31'd0, V}, {31'd0, exp_e[9]});
`endif
      end
    end
    start = 1'b0;
    check("b2b_queue_empty", exp_q.size(), 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
